timer_controller: RTL
=====================

Name: timer_controller

Overview:
Control FSM for the 60-second timer. It drives the digit counters' Hold/Direction command inputs and watches their digit values to detect expiry. It also generates the 1-per-CLK_DIV tick, expressed as a single-cycle Hold deassertion, and issues a counter reset pulse on Clear. It sits between user buttons and the tens/ones counter chain.

Parameters:
CLK_DIV, 4, Clock cycles per count tick in RUN (minimum 2; prescaler width clog2(CLK_DIV)).
UP_TENS, 5, Tens digit value that ends an up-count.
UP_ONES, 9, Ones digit value that ends an up-count.

Ports:
Clock  input  1  System clock, all state changes on its rising edge.
Reset  input  1  Synchronous, active-low reset.
Start  input  1  Start/resume button, synchronous level; rising edge acts.
Stop  input  1  Pause button, synchronous level; rising edge acts.
Clear  input  1  Clear button, synchronous level; rising edge acts.
Mode  input  1  Count direction requested at Start: 0 = up, 1 = down.
Tens  input  4  Tens digit from counter chain.
Ones  input  4  Ones digit from counter chain.
Direction  output  1  To counters: 0 = up, 1 = down.
Hold  output  1  To counters: 0 for exactly one cycle per tick, else 1.
CounterReset  output  1  Active-low reset to counters.
Running  output  1  High in RUN.
Expired  output  1  High in DONE.
State  output  2  Current state encoding.

Behaviour:
- Reset is synchronous, active-low, sampled on the Clock rising edge. While Reset = 0:
  - State = IDLE (00), Direction = 1, Hold = 1, CounterReset = 0, Running = 0, Expired = 0, prescaler = 0.
  - Button previous-value registers are set to 1, so a button held through reset produces no edge.
- Edge detect: an event fires in cycle N when the input is 1 and its registered previous value is 0.
- Event priority: Clear > Stop > Start.
- States: IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11.
- Clear edge, any state:
  - Next state is IDLE.
  - CounterReset = 0 for exactly the one following cycle.
  - Prescaler is cleared.
- IDLE, Start edge:
  - Direction <= Mode.
  - If (Mode = 1 and Tens = 0 and Ones = 0) or (Mode = 0 and Tens = UP_TENS and Ones = UP_ONES), next state is DONE.
  - Otherwise next state is RUN.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps. It is 0 in the first RUN cycle.
  - A tick occurs when prescaler = CLK_DIV-1, so the first tick is in the CLK_DIV-th RUN cycle.
  - On a tick with terminal digits present (down: 00; up: UP_TENS/UP_ONES), next state is DONE and Hold stays 1. No wrap is ever issued.
  - On a tick with non-terminal digits, Hold = 0 for that cycle only.
  - Stop edge: next state is PAUSE. The tick in that same cycle is suppressed (Hold = 1).
- PAUSE:
  - Hold = 1.
  - Start edge: next state is RUN with prescaler restarted at 0; Direction is unchanged.
  - Stop edge: no effect.
- DONE:
  - Hold = 1, Expired = 1.
  - Start and Stop edges are ignored; only Clear exits.
- Output decoding:
  - Hold = 0 iff (State = RUN, tick, digits non-terminal, no Stop/Clear edge this cycle). This is combinational from registers and edge detects only.
  - Direction changes only on an IDLE->RUN/DONE transition or on reset.
  - Running and Expired are decoded from State.
- Digits above 9 (ones) or above 5 (tens) are not terminal; counting proceeds without error.

Decomposition:
- Package timer_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and direction constants (DIR_UP = 0, DIR_DOWN = 1).
- Sub-module timer_prescaler: enable input, synchronous clear, wrap at CLK_DIV, single-cycle tick output.
- Edge detection stays inline.

Test Plan:
1. Reset low 3 cycles with Start held high, then Reset high -> State 00, Hold 1, CounterReset 0 during reset and 1 after; no transition until Start falls and rises again.
2. CLK_DIV = 4, Mode = 1, Tens/Ones = 0/3, Start pulse -> State 01 next cycle; Hold = 0 in RUN cycles 4, 8, 12. With the bench model decrementing, at 0/0 the next tick -> State 11, Expired = 1, Hold stays 1.
3. Mode = 0, digits 5/8, Start -> one Hold-low pulse (digits 5/9), then the next tick -> DONE. No Hold-low is ever issued at 5/9.
4. RUN with Stop edge coinciding with a tick -> Hold stays 1, State 10. Start edge -> State 01 and the next Hold-low is CLK_DIV cycles later; Direction unchanged.
5. Stop and Start edges in the same cycle during RUN -> PAUSE. Clear and Start together in PAUSE -> IDLE with CounterReset low for exactly 1 cycle.
6. Mode = 1, digits 0/0, Start in IDLE -> DONE the next cycle with no Hold-low. Start and Stop in DONE -> no change. Clear -> IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : State encodings, direction constants and terminal-digit helper
//               shared by the 60-second timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Down-counts end at 00; up-counts end at the configured tens/ones pair.
    function automatic logic digits_terminal(
        input logic       dir,
        input logic [3:0] tens,
        input logic [3:0] ones,
        input logic [3:0] up_tens,
        input logic [3:0] up_ones
    );
        if (dir == DIR_DOWN)
            return (tens == 4'd0) && (ones == 4'd0);
        return (tens == up_tens) && (ones == up_ones);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Wrapping 0..CLK_DIV-1 cycle counter with single-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              c_W    = $clog2(CLK_DIV);
    localparam logic [c_W-1:0]  c_last = c_W'(CLK_DIV - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/timer_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer_controller
// Description : Button-driven control FSM for the tens/ones timer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_controller
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int UP_TENS = 5,
    parameter int UP_ONES = 9
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       Mode,
    input  logic [3:0] Tens,
    input  logic [3:0] Ones,
    output logic       Direction,
    output logic       Hold,
    output logic       CounterReset,
    output logic       Running,
    output logic       Expired,
    output logic [1:0] State
);

    localparam logic [3:0] c_up_tens = 4'(UP_TENS);
    localparam logic [3:0] c_up_ones = 4'(UP_ONES);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_direction;
    logic   r_cnt_rst_n;
    logic   r_start_q;
    logic   r_stop_q;
    logic   r_clear_q;

    logic   w_start_ev;
    logic   w_stop_ev;
    logic   w_clear_ev;
    logic   w_tick;
    logic   w_run_term;
    logic   w_start_term;
    logic   w_hold;
    logic   w_load_dir;
    logic   w_presc_clr;

    assign w_start_ev = Start && !r_start_q;
    assign w_stop_ev  = Stop  && !r_stop_q;
    assign w_clear_ev = Clear && !r_clear_q;

    assign w_run_term   = digits_terminal(r_direction, Tens, Ones, c_up_tens, c_up_ones);
    assign w_start_term = digits_terminal(Mode, Tens, Ones, c_up_tens, c_up_ones);

    // Held at zero outside RUN so every entry into RUN starts a full period.
    assign w_presc_clr = w_clear_ev || (r_state != ST_RUN);

    timer_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (Clock),
        .rst_n  (Reset),
        .i_en   (r_state == ST_RUN),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold      = 1'b1;
        w_load_dir  = 1'b0;
        if (w_clear_ev) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ev && !w_stop_ev) begin
                        w_load_dir  = 1'b1;
                        w_state_nxt = w_start_term ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_stop_ev) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick) begin
                        if (w_run_term) w_state_nxt = ST_DONE;
                        else            w_hold      = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_start_ev && !w_stop_ev) w_state_nxt = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_direction <= DIR_DOWN;
            r_cnt_rst_n <= 1'b0;
            r_start_q   <= 1'b1;
            r_stop_q    <= 1'b1;
            r_clear_q   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt_rst_n <= !w_clear_ev;
            r_start_q   <= Start;
            r_stop_q    <= Stop;
            r_clear_q   <= Clear;
            if (w_load_dir) r_direction <= Mode;
        end
    end

    assign Direction    = r_direction;
    assign Hold         = w_hold;
    assign CounterReset = r_cnt_rst_n;
    assign Running      = (r_state == ST_RUN);
    assign Expired      = (r_state == ST_DONE);
    assign State        = r_state;

endmodule
`default_nettype wire
